dmem_wb_bridge: RTL
===================

# dmem_wb_bridge

Data-memory bridge converting the core's load/store request/response port into single Wishbone classic master cycles. Sits directly upstream of the Wishbone RAM and peripheral slaves: generates byte selects and lane-replicated write data, extracts and sign/zero-extends read data, rejects misaligned accesses without touching the bus, and aborts cycles that are never acknowledged.

## Interface
- ADDR_WIDTH, 16: byte address width presented to the bus; wb_adr_o carries bits [ADDR_WIDTH-1:2].
- TIMEOUT_CYCLES, 255: cycles wb_cyc_o may stay high without wb_ack_i before abort; range 1–65535.

- wb_clk_i  in  1  single clock, rising edge.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  bridge can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_wdata_i  in  32  store data, right-aligned.
- resp_valid_o  out  1  one-cycle response pulse; no backpressure.
- resp_rdata_o  out  32  extended load data; 0 for stores and errors.
- resp_err_o  out  1  misaligned, illegal size, or timeout.
- wb_adr_o  out  ADDR_WIDTH-2  word address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  4  byte lane selects.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.
- wb_ack_i  in  1  slave acknowledge.

## Operation
- FSM states: IDLE, BUS. All outputs registered.
- Accept = req_valid_i & req_ready_o at a rising edge.
- Alignment error: size 01 with addr[0]=1; size 10 with addr[1:0]≠0; size 11. Error accept: stay IDLE, no bus cycle, next cycle resp_valid_o=1, resp_err_o=1, resp_rdata_o=0.
- Legal accept: IDLE→BUS. Drive wb_cyc_o=wb_stb_o=1, wb_adr_o=addr[ADDR_WIDTH-1:2], wb_we_o=req_we_i; clear timeout counter; req_ready_o=0.
- Selects: byte → 4'b0001<<addr[1:0]; half → addr[1] ? 1100 : 0011; word → 1111. wb_sel_o is driven with the same value for loads and stores.
- Write data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- In BUS, wb_adr/dat/we/sel remain stable until cycle end.
- BUS with wb_ack_i=1: drop cyc/stb at that edge, →IDLE, resp_valid_o=1 next cycle, resp_err_o=0.
  - Load: resp_rdata_o = extend(wb_dat_i >> 8*addr[1:0]) to the access size.
  - Store: resp_rdata_o = 0.
- BUS without ack: counter increments. When counter = TIMEOUT_CYCLES-1 and no ack: drop cyc/stb, →IDLE, respond with resp_err_o=1, rdata=0. Ack on that same edge wins (normal response).
- req_ready_o returns to 1 at the edge that raises resp_valid_o. A new request may be accepted in the response cycle (back-to-back).
- wb_ack_i while IDLE is ignored.

## Timing
- Reset (wb_rst_ni low, immediate, asynchronous): state IDLE; req_ready_o=0; resp_valid_o=0; resp_err_o=0; resp_rdata_o=0; wb_cyc_o=wb_stb_o=wb_we_o=0; wb_sel_o=0; wb_adr_o=0; wb_dat_o=0.
- req_ready_o rises at the first rising edge after deassertion.
- Reset mid-cycle: bus cycle abandoned immediately; no response is issued.
- Legal access: cyc/stb high the cycle after accept.
- With a slave acking one cycle after seeing cyc, resp_valid_o is high 3 cycles after the accept edge. Example: accept at edge E0; cyc high after E0; ack high after E1; resp_valid_o high after E2.
- Misaligned access: resp_valid_o is high in the cycle after the accept edge.
- Timeout: cyc high for exactly TIMEOUT_CYCLES cycles; resp_valid_o is high in the following cycle.
- resp_valid_o is exactly one cycle wide. resp_rdata_o and resp_err_o hold until the next response.

## Test plan
- Word store then load at 0x0000_0010, data 0xDEADBEEF, single-wait slave: wb_sel_o=1111, wb_adr_o=0x4; load returns 0xDEADBEEF, err=0; resp_valid_o 3 cycles after each accept.
- Byte store 0xA5 at 0x13, then signed byte load at 0x13: wb_sel_o=1000, wb_dat_o=0xA5A5A5A5; load rdata=0xFFFFFFA5. Unsigned load returns 0x000000A5.
- Half load at 0x22, slave returns 0x8001_7FFF: signed rdata=0xFFFF8001; wb_sel_o=1100.
- Misaligned cases (half at 0x1, word at 0x2, size 11): err=1 one cycle after accept; wb_cyc_o never rises.
- No-ack slave, TIMEOUT_CYCLES=8: cyc high for 8 cycles, then err=1, rdata=0. Repeat with ack arriving on the 8th cycle: err=0 and data returned.
- Reset pulsed while in BUS: wb_cyc_o falls without a clock edge, no resp_valid_o pulse; the next request completes normally.

Source files
------------

// File: rtl/dmem_wb_bridge_if.sv
// dmem_wb_bridge_if: Wishbone classic bus between the data-memory bridge and its slaves
interface dmem_wb_bridge_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-3:0] adr;
  logic [31:0]           dat_w;
  logic [31:0]           dat_r;
  logic                  we;
  logic [3:0]            sel;
  logic                  stb;
  logic                  cyc;
  logic                  ack;
  modport master (output adr, dat_w, we, sel, stb, cyc, input dat_r, ack);
  modport slave  (input adr, dat_w, we, sel, stb, cyc, output dat_r, ack);
endinterface

// File: rtl/dmem_wb_bridge.sv
// dmem_wb_bridge: core load/store port to single Wishbone classic cycles with alignment check and timeout
module dmem_wb_bridge #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [31:0]            req_addr_i,
  input  logic [1:0]             req_size_i,
  input  logic                   req_unsigned_i,
  input  logic [31:0]            req_wdata_i,
  output logic                   resp_valid_o,
  output logic [31:0]            resp_rdata_o,
  output logic                   resp_err_o,
  dmem_wb_bridge_if.master       wb
);
  typedef enum logic {IDLE, BUS} state_t;
  state_t      state;
  logic [15:0] timer;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic        accept;
  logic        misaligned;
  logic [3:0]  sel_d;
  logic [31:0] wdat_d;
  logic [31:0] sh;
  logic [31:0] ext;
  logic        unused_addr;
  assign unused_addr = ^req_addr_i;
  assign accept = req_valid_i & req_ready_o;
  assign sh = wb.dat_r >> {off_q, 3'b000};
  // decode lane selects, replicated store data, alignment and the extended load result
  always_comb begin
    misaligned = (req_size_i == 2'b11) | (req_size_i == 2'b01 & req_addr_i[0]) |
                 (req_size_i == 2'b10 & |req_addr_i[1:0]);
    sel_d  = req_size_i == 2'b00 ? 4'b0001 << req_addr_i[1:0] :
             req_size_i == 2'b01 ? (req_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdat_d = req_size_i == 2'b00 ? {4{req_wdata_i[7:0]}} :
             req_size_i == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
    ext    = size_q == 2'b00 ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
             size_q == 2'b01 ? {{16{~uns_q & sh[15]}}, sh[15:0]} : sh;
  end
  // control FSM: accept or reject requests, run one bus cycle, respond on ack or timeout
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= IDLE;
      timer        <= '0;
      size_q       <= '0;
      off_q        <= '0;
      uns_q        <= 1'b0;
      req_ready_o  <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
      wb.cyc       <= 1'b0;
      wb.stb       <= 1'b0;
      wb.we        <= 1'b0;
      wb.sel       <= '0;
      wb.adr       <= '0;
      wb.dat_w     <= '0;
    end else begin
      resp_valid_o <= 1'b0;
      if (state == IDLE) begin
        req_ready_o <= ~(accept & ~misaligned);
        if (accept && misaligned) begin
          resp_valid_o <= 1'b1;
          resp_err_o   <= 1'b1;
          resp_rdata_o <= '0;
        end else if (accept) begin
          state    <= BUS;
          timer    <= '0;
          size_q   <= req_size_i;
          off_q    <= req_addr_i[1:0];
          uns_q    <= req_unsigned_i;
          wb.cyc   <= 1'b1;
          wb.stb   <= 1'b1;
          wb.we    <= req_we_i;
          wb.sel   <= sel_d;
          wb.adr   <= req_addr_i[ADDR_WIDTH-1:2];
          wb.dat_w <= wdat_d;
        end
      end else if (wb.ack || timer == 16'(TIMEOUT_CYCLES - 1)) begin
        state        <= IDLE;
        wb.cyc       <= 1'b0;
        wb.stb       <= 1'b0;
        req_ready_o  <= 1'b1;
        resp_valid_o <= 1'b1;
        resp_err_o   <= ~wb.ack;
        resp_rdata_o <= (wb.ack && !wb.we) ? ext : '0;
      end else begin
        timer <= timer + 16'd1;
      end
    end
  end
endmodule
